// File: rtl/fpga_template_pkg.sv
// Shared types and constants for the sample-buffer / frame-power datapath.
package fpga_template_pkg;
  localparam int SAMPLE_WIDTH = 36;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } frame_power_state_t;
endpackage

// File: rtl/signed_square_reg.sv
// Registered signed squarer plus registered magnitude, with a matching valid bit.
module signed_square_reg #(
  parameter int WIDTH = 36
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_vld_i,
  input  logic signed [WIDTH-1:0] x_i,
  output logic [2*WIDTH-1:0]      sq_o,
  output logic [WIDTH-1:0]        abs_o,
  output logic                    vld_o
);
  logic signed [2*WIDTH-1:0] x_ext;
  logic [WIDTH-1:0]          abs_c;

  assign x_ext = {{WIDTH{x_i[WIDTH-1]}}, x_i};
  // The most-negative input wraps to exactly 2^(WIDTH-1) in unsigned form.
  assign abs_c = x_i[WIDTH-1] ? (~x_i + 1'b1) : x_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sq_o  <= '0;
      abs_o <= '0;
      vld_o <= 1'b0;
    end else begin
      vld_o <= in_vld_i;
      if (in_vld_i) begin
        sq_o  <= x_ext * x_ext;
        abs_o <= abs_c;
      end
    end
  end
endmodule

// File: rtl/frame_power_meter.sv
// Drains one frame per frame_start_i, accumulating sum of squares and peak |x|;
// presents mean power and peak until the result consumer accepts them.
module frame_power_meter
  import fpga_template_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_WIDTH,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ACC_WIDTH  = 2*WIDTH + ADDR_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    frame_start_i,
  input  logic signed [WIDTH-1:0] sample_i,
  input  logic                    sample_valid_i,
  output logic                    sample_ready_o,
  output logic [2*WIDTH-1:0]      power_o,
  output logic [WIDTH-1:0]        peak_o,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic                    frame_overrun_o,
  output logic [ADDR_WIDTH:0]     sample_count_o
);
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);

  frame_power_state_t   state;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]     peak, peak_nxt;
  logic [2*WIDTH-1:0]   sq_q;
  logic [WIDTH-1:0]     abs_q;
  logic                 sq_vld_q;
  logic                 accept, last_accept, res_hs, start;

  assign accept      = sample_valid_i & sample_ready_o;
  assign last_accept = accept && (sample_count_o == LAST_IDX);
  assign res_hs      = (state == HOLD) && result_ready_i;
  assign start       = frame_start_i && ((state == IDLE) || res_hs);
  assign frame_overrun_o = frame_start_i && (state != IDLE) && !res_hs;

  signed_square_reg #(.WIDTH(WIDTH)) u_sq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .in_vld_i(accept),
    .x_i     (sample_i),
    .sq_o    (sq_q),
    .abs_o   (abs_q),
    .vld_o   (sq_vld_q)
  );

  // FLUSH latches these, so the final product is already folded in.
  assign acc_nxt  = acc + (sq_vld_q ? {{ADDR_WIDTH{1'b0}}, sq_q} : '0);
  assign peak_nxt = (sq_vld_q && (abs_q > peak)) ? abs_q : peak;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      acc            <= '0;
      peak           <= '0;
      sample_count_o <= '0;
      sample_ready_o <= 1'b0;
      result_valid_o <= 1'b0;
      power_o        <= '0;
      peak_o         <= '0;
    end else begin
      acc  <= acc_nxt;
      peak <= peak_nxt;
      if (accept) sample_count_o <= sample_count_o + 1'b1;
      unique case (state)
        IDLE:  ;
        ACCUM: if (last_accept) begin
          state          <= FLUSH;
          sample_ready_o <= 1'b0;
        end
        FLUSH: begin
          state          <= HOLD;
          result_valid_o <= 1'b1;
          power_o        <= acc_nxt[ACC_WIDTH-1:ADDR_WIDTH];
          peak_o         <= peak_nxt;
        end
        HOLD: if (res_hs) begin
          state          <= IDLE;
          result_valid_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (start) begin
        state          <= ACCUM;
        sample_ready_o <= 1'b1;
        acc            <= '0;
        peak           <= '0;
        sample_count_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_frame_power_meter.sv
// Randomized and directed checks of frame_power_meter against an arithmetic model.
module tb_frame_power_meter;
  localparam int W  = 36;
  localparam int D  = 8;
  localparam int AW = 3;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                frame_start_i = 1'b0;
  logic signed [W-1:0] sample_i = '0;
  logic                sample_valid_i = 1'b0;
  logic                sample_ready_o;
  logic [2*W-1:0]      power_o;
  logic [W-1:0]        peak_o;
  logic                result_valid_o;
  logic                result_ready_i = 1'b0;
  logic                frame_overrun_o;
  logic [AW:0]         sample_count_o;

  int n_chk = 0;
  int n_pass = 0;
  logic signed [W-1:0] frm [D];

  always #5 clk = ~clk;

  frame_power_meter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .frame_start_i  (frame_start_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .power_o        (power_o),
    .peak_o         (peak_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .frame_overrun_o(frame_overrun_o),
    .sample_count_o (sample_count_o)
  );

  // Mean of squares, from exact wide arithmetic and an integer division.
  function automatic logic [2*W-1:0] mdl_power();
    logic [2*W+AW-1:0] s;
    logic signed [2*W-1:0] v;
    logic [2*W-1:0] p;
    s = '0;
    for (int i = 0; i < D; i++) begin
      v = frm[i];
      p = v * v;
      s = s + (2*W+AW)'(p);
    end
    return (2*W)'(s / D);
  endfunction

  function automatic logic [W-1:0] mdl_peak();
    logic signed [W:0] w;
    logic [W:0] m;
    m = '0;
    for (int i = 0; i < D; i++) begin
      w = frm[i];
      if (w < 0) w = -w;
      if (w > m) m = w;
    end
    return m[W-1:0];
  endfunction

  task automatic fill_const(input logic signed [W-1:0] v);
    for (int i = 0; i < D; i++) frm[i] = v;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    frame_start_i = 1'b1;
    @(posedge clk);
    #1 frame_start_i = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    result_ready_i = 1'b1;
    @(posedge clk);
    #1 result_ready_i = 1'b0;
  endtask

  // Offers frm[] under a valid pattern (0 held, 1 toggling, 2 random); optionally
  // raises frame_start_i once when `ov_at` samples have gone in.
  task automatic feed(input int n, input int mode, input int ov_at,
                      output int got, output int ov_cnt);
    int cyc;
    bit acc, ov_done;
    got = 0; ov_cnt = 0; cyc = 0; ov_done = 0;
    while (got < n && cyc < 300) begin
      @(negedge clk);
      case (mode)
        0:       sample_valid_i = 1'b1;
        1:       sample_valid_i = (cyc % 2 == 0);
        default: sample_valid_i = ($urandom_range(0, 2) != 0);
      endcase
      sample_i = frm[got];
      if (got == ov_at && !ov_done) begin
        frame_start_i = 1'b1;
        ov_done = 1;
      end
      #1;
      if (frame_overrun_o) ov_cnt++;
      acc = sample_valid_i && sample_ready_o;
      @(posedge clk);
      if (acc) got++;
      cyc++;
      #1 frame_start_i = 1'b0;
    end
    sample_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    sample_valid_i = 1'b1;
    frame_start_i = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({sample_ready_o, result_valid_o, frame_overrun_o, sample_count_o, power_o, peak_o} !== '0)
      $display("FAIL reset_outputs got rdy=%b vld=%b ov=%b cnt=%0d pwr=%0d pk=%0d want all 0",
               sample_ready_o, result_valid_o, frame_overrun_o, sample_count_o, power_o, peak_o);
    else n_pass++;
    sample_valid_i = 1'b0;
    frame_start_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (sample_ready_o !== 1'b0 || sample_count_o !== '0)
      $display("FAIL idle_after_reset got rdy=%b cnt=%0d want 0/0", sample_ready_o, sample_count_o);
    else n_pass++;
  endtask

  task automatic test_const_frame();
    int got, ov;
    fill_const(36'sd3);
    pulse_start();
    feed(D, 0, -1, got, ov);
    @(negedge clk);
    n_chk++;
    if ({sample_ready_o, result_valid_o, sample_count_o} !== {1'b0, 1'b0, 4'd8})
      $display("FAIL t1_flush got rdy=%b vld=%b cnt=%0d want 0 0 8",
               sample_ready_o, result_valid_o, sample_count_o);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (result_valid_o !== 1'b1 || power_o !== mdl_power() || peak_o !== mdl_peak())
      $display("FAIL t1_result got vld=%b pwr=%0d pk=%0d want 1 %0d %0d",
               result_valid_o, power_o, peak_o, mdl_power(), mdl_peak());
    else n_pass++;
    n_chk++;
    if (power_o !== 72'd9 || peak_o !== 36'd3)
      $display("FAIL t1_literal got pwr=%0d pk=%0d want 9 3", power_o, peak_o);
    else n_pass++;
    handshake();
    @(negedge clk);
    n_chk++;
    if (result_valid_o !== 1'b0 || power_o !== 72'd9 || peak_o !== 36'd3 || sample_count_o !== 4'd8)
      $display("FAIL t1_retain got vld=%b pwr=%0d pk=%0d cnt=%0d want 0 9 3 8",
               result_valid_o, power_o, peak_o, sample_count_o);
    else n_pass++;
  endtask

  task automatic test_toggle_valid();
    int got, ov;
    for (int i = 0; i < D; i++) frm[i] = (i % 2 == 0) ? 36'sd1000 : -36'sd1000;
    pulse_start();
    feed(D, 1, -1, got, ov);
    repeat (2) @(negedge clk);
    sample_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (sample_count_o !== 4'd8 || got != D)
      $display("FAIL t2_count got cnt=%0d fed=%0d want 8 8", sample_count_o, got);
    else n_pass++;
    n_chk++;
    if (power_o !== 72'd1000000 || peak_o !== 36'd1000 || result_valid_o !== 1'b1)
      $display("FAIL t2_result got pwr=%0d pk=%0d vld=%b want 1000000 1000 1",
               power_o, peak_o, result_valid_o);
    else n_pass++;
    sample_valid_i = 1'b0;
    handshake();
  endtask

  task automatic test_most_negative();
    int got, ov;
    fill_const('0);
    frm[0] = 36'sh8_0000_0000;
    pulse_start();
    feed(D, 0, -1, got, ov);
    repeat (2) @(negedge clk);
    n_chk++;
    if (power_o !== (72'd1 << 67) || peak_o !== (36'd1 << 35) || power_o !== mdl_power())
      $display("FAIL t3_minneg got pwr=%h pk=%h want %h %h",
               power_o, peak_o, (72'd1 << 67), (36'd1 << 35));
    else n_pass++;
    handshake();
  endtask

  task automatic test_overrun_hold();
    int got, ov;
    logic [2*W-1:0] ep;
    logic [W-1:0] ek;
    for (int i = 0; i < D; i++) frm[i] = 36'(i + 1) * 36'sd7 - 36'sd20;
    ep = mdl_power();
    ek = mdl_peak();
    pulse_start();
    feed(D, 0, 3, got, ov);
    n_chk++;
    if (ov != 1 || got != D)
      $display("FAIL t4_overrun got pulses=%0d fed=%0d want 1 8", ov, got);
    else n_pass++;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if ({result_valid_o, sample_ready_o, power_o, peak_o} !== {1'b1, 1'b0, ep, ek})
        $display("FAIL t4_hold_c%0d got vld=%b rdy=%b pwr=%0d pk=%0d want 1 0 %0d %0d",
                 i, result_valid_o, sample_ready_o, power_o, peak_o, ep, ek);
      else n_pass++;
      if (i == 5) begin
        frame_start_i = 1'b1;
        #1;
        n_chk++;
        if (frame_overrun_o !== 1'b1)
          $display("FAIL t4_hold_overrun got %b want 1", frame_overrun_o);
        else n_pass++;
        @(posedge clk);
        #1 frame_start_i = 1'b0;
      end
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int got, ov;
    fill_const(36'sd5);
    pulse_start();
    feed(D, 0, -1, got, ov);
    repeat (2) @(negedge clk);
    result_ready_i = 1'b1;
    frame_start_i = 1'b1;
    #1;
    n_chk++;
    if (frame_overrun_o !== 1'b0 || result_valid_o !== 1'b1)
      $display("FAIL t5_no_overrun got ov=%b vld=%b want 0 1", frame_overrun_o, result_valid_o);
    else n_pass++;
    @(posedge clk);
    #1;
    result_ready_i = 1'b0;
    frame_start_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({sample_ready_o, result_valid_o, sample_count_o} !== {1'b1, 1'b0, 4'd0})
      $display("FAIL t5_restart got rdy=%b vld=%b cnt=%0d want 1 0 0",
               sample_ready_o, result_valid_o, sample_count_o);
    else n_pass++;
    fill_const(36'sd2);
    feed(D, 0, -1, got, ov);
    repeat (2) @(negedge clk);
    n_chk++;
    if (power_o !== 72'd4 || peak_o !== 36'd2 || result_valid_o !== 1'b1)
      $display("FAIL t5_second got pwr=%0d pk=%0d vld=%b want 4 2 1", power_o, peak_o, result_valid_o);
    else n_pass++;
    handshake();
  endtask

  task automatic test_async_reset();
    int got, ov;
    fill_const(36'sd9);
    pulse_start();
    feed(5, 0, -1, got, ov);
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    n_chk++;
    if ({sample_ready_o, result_valid_o, frame_overrun_o, sample_count_o, power_o, peak_o} !== '0)
      $display("FAIL t6_async got rdy=%b vld=%b cnt=%0d pwr=%0d pk=%0d want all 0",
               sample_ready_o, result_valid_o, sample_count_o, power_o, peak_o);
    else n_pass++;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (result_valid_o !== 1'b0)
      $display("FAIL t6_no_partial got vld=%b want 0", result_valid_o);
    else n_pass++;
    fill_const(36'sd1);
    pulse_start();
    feed(D, 0, -1, got, ov);
    repeat (2) @(negedge clk);
    n_chk++;
    if (power_o !== 72'd1 || peak_o !== 36'd1 || result_valid_o !== 1'b1)
      $display("FAIL t6_recover got pwr=%0d pk=%0d vld=%b want 1 1 1", power_o, peak_o, result_valid_o);
    else n_pass++;
    handshake();
  endtask

  task automatic test_random();
    int got, ov, wcyc;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < D; i++) begin
        case ($urandom_range(0, 3))
          0:       frm[i] = 36'({$urandom, $urandom});
          1:       frm[i] = 36'($urandom_range(0, 2000)) - 36'sd1000;
          2:       frm[i] = 36'sh7_FFFF_FFFF;
          default: frm[i] = 36'sh8_0000_0000;
        endcase
      end
      pulse_start();
      feed(D, 2, -1, got, ov);
      wcyc = 0;
      @(negedge clk);
      while (result_valid_o !== 1'b1 && wcyc < 10) begin
        @(negedge clk);
        wcyc++;
      end
      n_chk++;
      if (result_valid_o !== 1'b1 || power_o !== mdl_power() || peak_o !== mdl_peak() || ov != 0)
        $display("FAIL rand_f%0d got vld=%b pwr=%h pk=%h ov=%0d want 1 %h %h 0",
                 f, result_valid_o, power_o, peak_o, ov, mdl_power(), mdl_peak());
      else n_pass++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_const_frame();
    test_toggle_valid();
    test_most_negative();
    test_overrun_hold();
    test_back_to_back();
    test_async_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/frame_power_meter.md
Name: frame_power_meter

Overview:
Consumer stage directly downstream of the ping-pong sample buffer. On each buffer-ready pulse it drains one full frame of DEPTH signed samples over a valid/ready handshake. It accumulates the sum of squares and the peak absolute value for the frame. It then presents mean power and peak as one result word, held until the control/telemetry logic accepts it.

Parameters:
WIDTH, 36, sample width (signed two's complement)
DEPTH, 256, samples per frame; must be a power of two, >= 2
ADDR_WIDTH, $clog2(DEPTH), frame index width
ACC_WIDTH, 2*WIDTH+ADDR_WIDTH, accumulator width; guarantees no overflow

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  asynchronous, active-high reset
frame_start_i  in  1  one-cycle pulse: a full frame is readable (from upstream buffer_ready)
sample_i  in  WIDTH signed  frame sample
sample_valid_i  in  1  sample_i valid
sample_ready_o  out  1  block accepts a sample this cycle
power_o  out  2*WIDTH unsigned  mean of squares for the last frame
peak_o  out  WIDTH unsigned  max |sample| for the last frame
result_valid_o  out  1  power_o/peak_o valid
result_ready_i  in  1  result consumer ready
frame_overrun_o  out  1  one-cycle pulse: frame_start_i arrived while busy
sample_count_o  out  ADDR_WIDTH+1  samples accepted in the current frame

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0; accumulator, peak, count and product pipeline cleared.
- States: IDLE, ACCUM, FLUSH, HOLD.
- IDLE, on frame_start_i=1: go to ACCUM; clear acc, peak and count.
- ACCUM: sample_ready_o=1 while count<DEPTH. Accept = sample_valid_i & sample_ready_o.
- Each accept: register sq_q <= sample_i*sample_i (2*WIDTH unsigned) and sq_vld_q <= 1; update peak if |sample_i| > peak; count += 1.
- Each cycle with sq_vld_q=1: acc += zero-extended sq_q. Squaring latency is 1 cycle; accumulation completes 1 cycle later.
- |x| is computed in WIDTH-bit unsigned. The most-negative input -2^(WIDTH-1) yields 2^(WIDTH-1) exactly; no saturation.
- DEPTH-th accept: go to FLUSH. sample_ready_o=0 from the next cycle.
- FLUSH: one cycle, so the last product enters acc. Then go to HOLD.
- HOLD: result_valid_o=1; power_o = acc[ACC_WIDTH-1:ADDR_WIDTH]; peak_o = peak. Outputs stay stable until result_valid_o & result_ready_i.
- On that result handshake: go to IDLE, or directly to ACCUM (cleared) if frame_start_i=1 in the same cycle. Back-to-back frames do not count as an overrun.
- frame_start_i in ACCUM, FLUSH, or HOLD without a same-cycle handshake: ignored; frame_overrun_o=1 for exactly that cycle. Frame progress is unaffected.
- sample_valid_i outside ACCUM: ignored; count unchanged.
- sample_count_o = count; it holds DEPTH through FLUSH and HOLD and returns to 0 on the next frame start.
- power_o and peak_o keep their last value after leaving HOLD. They update only on entering HOLD.
- Reset mid-frame: immediate abort, no partial result, no result_valid_o.

Decomposition:
- fpga_template_pkg gets the frame_power_state_t enum (IDLE/ACCUM/FLUSH/HOLD, 2 bits) and a shared SAMPLE_WIDTH=36 constant used here and by the buffer.
- One sub-module is natural: signed_square_reg. It is the registered signed squarer plus registered abs, with a valid bit, so the multiplier maps to a DSP block and can be deepened independently.

Test Plan:
1. DEPTH=8, frame_start pulse, then 8 samples of +3 with valid held high -> sample_ready drops after 8th; result_valid 2 cycles after 8th accept; power_o=9, peak_o=3, sample_count_o=8.
2. DEPTH=8, alternating +1000/-1000, valid toggling 1/0 every cycle -> exactly 8 accepts; power_o=1000000, peak_o=1000.
3. DEPTH=8, first sample -2^35 and seven zeros -> power_o=2^67, peak_o=2^35; no overflow, no X.
4. frame_start pulse after 3 accepts, result_ready_i low for 10 cycles in HOLD -> frame_overrun_o high 1 cycle, count continues 4..8; result_valid and outputs stable for 10 cycles; sample_ready_o=0 throughout HOLD.
5. frame_start_i coincident with the result handshake -> state goes straight to ACCUM; no overrun; second frame of all +2 gives power_o=4.
6. rst_i asserted asynchronously (mid-cycle) after 5 accepts -> all outputs 0 immediately; a subsequent full frame of +1 gives power_o=1, peak_o=1.
